mcu_spi: RTL and testbench
==========================

MCU_SPI -- requirements
Module: mcu_spi

Interface
REQ-001 SHALL have no parameters; the four target IDs are fixed: 0=sys, 1=hid, 2=osd, 3=sdc.
REQ-002 clk  input  1  system clock; one clock domain; SPI lines are sampled in it.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 spi_io_ss  input  1  MCU frame select, active low.
REQ-005 spi_io_clk  input  1  SPI clock, mode 0; each half-period is at least 4 clk cycles.
REQ-006 spi_io_din  input  1  MOSI; MSB first.
REQ-007 spi_io_dout  output  1  MISO; MSB first.
REQ-008 mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe  output  1 each  per-target byte strobe.
REQ-009 mcu_start  output  1  marks the command byte (first strobed byte of a frame).
REQ-010 mcu_dout  output  8  received byte towards the targets.
REQ-011 mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din  input  8 each  reply bytes from the targets.

Function
REQ-012 SHALL pass spi_io_ss, spi_io_clk and spi_io_din through 2-flop synchronizers, plus one extra stage on spi_io_clk for edge detection.
REQ-013 SHALL sample MOSI on each synchronized rising edge of SCLK into an 8-bit shift register and count bits 0..7; the count wraps to 0 after bit 7.
REQ-014 FSM states SHALL be IDLE, TARGET, COMMAND and PAYLOAD.
- IDLE->TARGET on the synchronized falling edge of ss.
- TARGET->COMMAND on byte completion; the byte is latched as the target ID.
- COMMAND->PAYLOAD on byte completion.
- PAYLOAD->PAYLOAD on each further byte completion.
REQ-015 Completion of the target byte SHALL produce no strobe.
REQ-016 On completion of the command byte, the selected target's strobe and mcu_start SHALL both be high for exactly 1 clk.
REQ-017 On completion of each payload byte, the selected strobe SHALL be high for 1 clk with mcu_start low.
REQ-018 mcu_dout SHALL carry the completed byte from the strobe cycle onward and hold it until the next strobe.
REQ-019 The strobe SHALL assert no later than 4 clk cycles after the raw SCLK rising edge of bit 7.
REQ-020 A target ID greater than 3 SHALL suppress all strobes for the rest of the frame; the frame is still clocked and the reply is 0x00.
REQ-021 Reply path: 2 clk cycles after each byte completion, the TX register SHALL load the selected target's din (0x00 for an invalid ID).
REQ-022 At frame start the TX register SHALL load 0x00.
REQ-023 The TX register SHALL shift left on each synchronized falling edge of SCLK.
REQ-024 spi_io_dout SHALL equal TX[7] while ss is low, and 0 while ss is high.
REQ-025 Deasserting ss mid-byte SHALL discard the partial bits, generate no strobe, clear the bit counter and return the FSM to IDLE.
REQ-026 An ss rising edge coinciding with byte completion SHALL still strobe that byte, then go to IDLE.
REQ-027 If ss is low when reset is released, the block SHALL ignore the bus until it sees an ss high-to-low transition.

Reset
REQ-028 Reset SHALL asynchronously force: FSM to IDLE; bit counter, shift registers and target register to 0; all strobes, mcu_start and spi_io_dout to 0; mcu_dout to 0x00.
REQ-029 Reset SHALL force the synchronizer flops to their inactive levels: ss=1, clk=0, din=0.

Configuration
REQ-030 With MCU_SPI_TIMEOUT_EN defined, a 16-bit counter SHALL clear on every SCLK edge and on ss high.
- When it reaches 0xFFFF while ss is low, the frame SHALL abort as in REQ-025.
- The block SHALL then ignore the bus until the next ss falling edge.
REQ-031 Without MCU_SPI_TIMEOUT_EN, there SHALL be no counter and no timeout; a stalled frame waits indefinitely.

Verification
REQ-032 Frame 0x01,0x02,0x05,0xFB -> mcu_hid_strobe pulses three times:
- 0x02 with mcu_start=1;
- 0x05 with mcu_start=0;
- 0xFB with mcu_start=0;
- no other strobe asserts.
REQ-033 Frame 0x00,0x00,0x00,0x00 with mcu_sys_din driven 0x01 -> MISO bytes read 0x00,0x01,0x01,0x01.
REQ-034 Target byte 0x07 followed by 3 bytes -> no strobe asserts and MISO reads all 0x00.
REQ-035 ss raised after 5 bits of the command byte, then a new frame 0x01,0x03 -> no strobe for the aborted frame, then a single mcu_hid_strobe with mcu_start=1 and mcu_dout=0x03.
REQ-036 Reset pulsed mid-payload with ss held low, then the frame continues -> no strobes until ss toggles high then low; all outputs read 0 while reset is high.
REQ-037 With MCU_SPI_TIMEOUT_EN defined, SCLK stopped for 70000 clk mid-byte with ss low -> FSM in IDLE, no strobe, and bytes ignored until the next ss falling edge.

Source files
------------

// File: rtl/mcu_spi_if.sv
// Pins of the MCU SPI slave plus the byte bus towards the sys/hid/osd/sdc targets.
// slave: the bridge itself; master: whatever drives SPI and supplies target reply bytes.
interface mcu_spi_if;
  logic       spi_io_ss;
  logic       spi_io_clk;
  logic       spi_io_din;
  logic       spi_io_dout;
  logic       mcu_sys_strobe;
  logic       mcu_hid_strobe;
  logic       mcu_osd_strobe;
  logic       mcu_sdc_strobe;
  logic       mcu_start;
  logic [7:0] mcu_dout;
  logic [7:0] mcu_sys_din;
  logic [7:0] mcu_hid_din;
  logic [7:0] mcu_osd_din;
  logic [7:0] mcu_sdc_din;

  modport slave (
    input  spi_io_ss, spi_io_clk, spi_io_din,
    input  mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din,
    output spi_io_dout, mcu_start, mcu_dout,
    output mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe
  );

  modport master (
    output spi_io_ss, spi_io_clk, spi_io_din,
    output mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din,
    input  spi_io_dout, mcu_start, mcu_dout,
    input  mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe
  );
endinterface

// File: rtl/mcu_spi.sv
// SPI mode-0 slave routing frames (target, command, payload) to four byte targets; strobe 3 clk after raw SCLK
// rise of bit 7, no backpressure (targets take every strobe). MCU_SPI_TIMEOUT_EN adds a 16-bit stall abort.
module mcu_spi (
  input  logic     clk,
  input  logic     reset,
  mcu_spi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TARGET, COMMAND, PAYLOAD} state_t;

  state_t     state, state_nxt;
  logic       ss_s1, ss_s2, ss_prev;
  logic       clk_s1, clk_s2, clk_s3;
  logic       din_s1, din_s2;
  logic [1:0] sync_vld;
  logic [2:0] bit_cnt;
  logic [6:0] shift_reg;
  logic [7:0] rx_byte, tgt_reg, tx_reg, sel_din, dout_r;
  logic [3:0] strobe_r;
  logic       start_r, ld_pend;
  logic       sclk_rise, sclk_fall, ss_fall, frame_start;
  logic       active, byte_done, abort, tgt_ok, timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_s1    <= 1'b1;
      ss_s2    <= 1'b1;
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_s3   <= 1'b0;
      din_s1   <= 1'b0;
      din_s2   <= 1'b0;
      sync_vld <= 2'b00;
      ss_prev  <= 1'b0;
    end else begin
      ss_s1    <= bus.spi_io_ss;
      ss_s2    <= ss_s1;
      clk_s1   <= bus.spi_io_clk;
      clk_s2   <= clk_s1;
      clk_s3   <= clk_s2;
      din_s1   <= bus.spi_io_din;
      din_s2   <= din_s1;
      sync_vld <= {sync_vld[0], 1'b1};
      // Only a real sampled ss high arms frame start, so ss held low across reset stays ignored.
      ss_prev  <= ss_s2 & sync_vld[1];
    end
  end

  assign sclk_rise   = clk_s2 & ~clk_s3;
  assign sclk_fall   = ~clk_s2 & clk_s3;
  assign ss_fall     = ss_prev & ~ss_s2;
  assign active      = (state != IDLE);
  assign frame_start = (state == IDLE) & ss_fall;
  assign byte_done   = active & sclk_rise & (bit_cnt == 3'd7);
  assign rx_byte     = {shift_reg, din_s2};
  assign abort       = active & (ss_s2 | timeout);
  assign tgt_ok      = (tgt_reg[7:2] == 6'd0);

`ifdef MCU_SPI_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      to_cnt <= 16'd0;
    else if (ss_s2 | sclk_rise | sclk_fall)
      to_cnt <= 16'd0;
    else if (to_cnt != 16'hFFFF)
      to_cnt <= to_cnt + 16'd1;
  end

  assign timeout = ~ss_s2 & (to_cnt == 16'hFFFF);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    sel_din = 8'h00;
    if (tgt_ok) begin
      case (tgt_reg[1:0])
        2'd0:    sel_din = bus.mcu_sys_din;
        2'd1:    sel_din = bus.mcu_hid_din;
        2'd2:    sel_din = bus.mcu_osd_din;
        default: sel_din = bus.mcu_sdc_din;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall)   state_nxt = TARGET;
      TARGET:  if (byte_done) state_nxt = COMMAND;
      COMMAND: if (byte_done) state_nxt = PAYLOAD;
      PAYLOAD: state_nxt = PAYLOAD;
      default: state_nxt = IDLE;
    endcase
    if (abort)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
      tgt_reg   <= 8'h00;
      tx_reg    <= 8'h00;
      strobe_r  <= 4'b0000;
      start_r   <= 1'b0;
      dout_r    <= 8'h00;
      ld_pend   <= 1'b0;
    end else begin
      strobe_r <= 4'b0000;
      start_r  <= 1'b0;
      ld_pend  <= byte_done;

      if (abort | frame_start)
        bit_cnt <= 3'd0;
      else if (active & sclk_rise) begin
        bit_cnt   <= bit_cnt + 3'd1;
        shift_reg <= rx_byte[6:0];
      end

      if (byte_done) begin
        if (state == TARGET)
          tgt_reg <= rx_byte;
        else if (tgt_ok) begin
          strobe_r <= 4'b0001 << tgt_reg[1:0];
          start_r  <= (state == COMMAND);
          dout_r   <= rx_byte;
        end
      end

      // The fall right after bit 7 must not shift: the reply byte is loaded around then and its MSB goes out first.
      if (frame_start)
        tx_reg <= 8'h00;
      else if (ld_pend)
        tx_reg <= sel_din;
      else if (active & sclk_fall & (bit_cnt != 3'd0))
        tx_reg <= {tx_reg[6:0], 1'b0};
    end
  end

  assign bus.spi_io_dout    = tx_reg[7] & ~ss_s2;
  assign bus.mcu_sys_strobe = strobe_r[0];
  assign bus.mcu_hid_strobe = strobe_r[1];
  assign bus.mcu_osd_strobe = strobe_r[2];
  assign bus.mcu_sdc_strobe = strobe_r[3];
  assign bus.mcu_start      = start_r;
  assign bus.mcu_dout       = dout_r;
endmodule

// File: tb/tb_mcu_spi.sv
// Bench for mcu_spi: bit-banged SPI master, strobe monitor and a per-frame reference model
// (events and MISO bytes derived from the frame rules alone).
module tb_mcu_spi;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mcu_spi_if bus();

  mcu_spi dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         last_rise = 0;
  int         hp      = 5;
  int         obs_q[$];
  int         exp_q[$];
  logic [7:0] fb[8];
  int         fn;
  logic [7:0] dv[4];
  logic [7:0] rx[8];
  logic [7:0] r;
  logic [3:0] mon_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Any strobe or start is an event: {strobes, start, byte}.
  always @(negedge clk) begin
    if (!reset) begin
      mon_s = {bus.mcu_sdc_strobe, bus.mcu_osd_strobe, bus.mcu_hid_strobe, bus.mcu_sys_strobe};
      if (mon_s != 4'b0000 || bus.mcu_start) begin
        obs_q.push_back(int'(mon_s) * 512 + (bus.mcu_start ? 256 : 0) + int'(bus.mcu_dout));
        check("strobe_latency", 32'(cyc - last_rise <= 4), 32'd1);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_din(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    bus.mcu_sys_din = a;
    bus.mcu_hid_din = b;
    bus.mcu_osd_din = c;
    bus.mcu_sdc_din = d;
  endtask

  // Sends the top nbits of b, MSB first; MISO is sampled just before each rising edge.
  task automatic xfer(input logic [7:0] b, input int nbits, input bit ss_up_last, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_io_din = b[7-i];
      wait_clk(hp);
      rd = {rd[6:0], bus.spi_io_dout};
      bus.spi_io_clk = 1'b1;
      last_rise = cyc;
      if (ss_up_last && i == nbits - 1) bus.spi_io_ss = 1'b1;
      wait_clk(hp);
      bus.spi_io_clk = 1'b0;
    end
  endtask

  task automatic model_frame();
    if (fb[0] < 8'd4)
      for (int i = 1; i < fn; i++)
        exp_q.push_back((1 << int'(fb[0])) * 512 + ((i == 1) ? 256 : 0) + int'(fb[i]));
  endtask

  task automatic compare_events(input string tag);
    check({tag, " strobe_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, " strobe_event"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " strobes"}, 32'({bus.mcu_sdc_strobe, bus.mcu_osd_strobe, bus.mcu_hid_strobe, bus.mcu_sys_strobe}), 32'd0);
    check({tag, " start"}, 32'(bus.mcu_start), 32'd0);
    check({tag, " dout"}, 32'(bus.mcu_dout), 32'd0);
    check({tag, " miso"}, 32'(bus.spi_io_dout), 32'd0);
  endtask

  task automatic run_frame(input string tag, input bit ss_on_last);
    model_frame();
    bus.spi_io_ss = 1'b0;
    wait_clk(hp);
    for (int i = 0; i < fn; i++) begin
      xfer(fb[i], 8, ss_on_last && i == fn - 1, r);
      rx[i] = r;
    end
    wait_clk(hp);
    bus.spi_io_ss = 1'b1;
    wait_clk(8);
    for (int i = 0; i < fn; i++)
      check({tag, " miso"}, 32'(rx[i]), (i == 0 || fb[0] > 8'd3) ? 32'd0 : 32'(dv[fb[0][1:0]]));
    if (fb[0] < 8'd4 && fn > 1)
      check({tag, " dout_hold"}, 32'(bus.mcu_dout), 32'(fb[fn-1]));
    compare_events(tag);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.spi_io_ss  = 1'b1;
    bus.spi_io_clk = 1'b0;
    bus.spi_io_din = 1'b0;
    set_din(8'h00, 8'h00, 8'h00, 8'h00);
    wait_clk(3);
    check_zero_outputs("reset");
    reset = 1'b0;
    wait_clk(6);

    // Three hid strobes, first one with start.
    hp = 4;
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h05; fb[3] = 8'hFB; fn = 4;
    set_din(8'h3C, 8'h81, 8'h00, 8'h7E);
    run_frame("hid_frame", 1'b0);

    // Reply path from sys.
    hp = 5;
    fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00; fn = 4;
    set_din(8'h01, 8'hFF, 8'hFF, 8'hFF);
    run_frame("sys_reply", 1'b0);

    // Invalid target: no strobes, MISO all zero.
    fb[0] = 8'h07; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33; fn = 4;
    set_din(8'hA5, 8'hA5, 8'hA5, 8'hA5);
    run_frame("bad_target", 1'b0);

    // ss raised after 5 bits of the command byte, then a clean frame.
    bus.spi_io_ss = 1'b0;
    wait_clk(hp);
    xfer(8'h01, 8, 1'b0, r);
    xfer(8'h42, 5, 1'b0, r);
    wait_clk(hp);
    bus.spi_io_ss = 1'b1;
    wait_clk(8);
    fb[0] = 8'h01; fb[1] = 8'h03; fn = 2;
    run_frame("after_abort", 1'b0);

    // ss rising together with the last SCLK rise still strobes that byte.
    fb[0] = 8'h03; fb[1] = 8'h9C; fb[2] = 8'h3E; fn = 3;
    run_frame("ss_on_last", 1'b1);

    // Reset mid-payload with ss low: bus ignored until ss toggles.
    hp = 4;
    set_din(8'h00, 8'h00, 8'h5A, 8'h00);
    fb[0] = 8'h02; fb[1] = 8'h11; fb[2] = 8'h22; fn = 3;
    model_frame();
    bus.spi_io_ss = 1'b0;
    wait_clk(hp);
    for (int i = 0; i < fn; i++) xfer(fb[i], 8, 1'b0, r);
    xfer(8'h77, 3, 1'b0, r);
    reset = 1'b1;
    wait_clk(2);
    check_zero_outputs("mid_reset");
    reset = 1'b0;
    xfer(8'h77, 5, 1'b0, r);
    xfer(8'h01, 8, 1'b0, r);
    check("post_reset miso", 32'(r), 32'd0);
    xfer(8'h44, 8, 1'b0, r);
    xfer(8'h55, 8, 1'b0, r);
    wait_clk(hp);
    bus.spi_io_ss = 1'b1;
    wait_clk(8);
    compare_events("post_reset");
    fb[0] = 8'h02; fb[1] = 8'hC3; fb[2] = 8'h18; fn = 3;
    run_frame("recovered", 1'b0);

`ifdef MCU_SPI_TIMEOUT_EN
    // SCLK stalls mid-byte long enough to time out; later bytes are ignored.
    hp = 4;
    bus.spi_io_ss = 1'b0;
    wait_clk(hp);
    xfer(8'h01, 8, 1'b0, r);
    xfer(8'h44, 3, 1'b0, r);
    wait_clk(70000);
    xfer(8'h20, 5, 1'b0, r);
    xfer(8'h55, 8, 1'b0, r);
    xfer(8'h66, 8, 1'b0, r);
    wait_clk(hp);
    bus.spi_io_ss = 1'b1;
    wait_clk(8);
    compare_events("timeout");
    fb[0] = 8'h01; fb[1] = 8'h4D; fn = 2;
    run_frame("after_timeout", 1'b0);
`else
    // A long SCLK stall mid-byte just delays the frame.
    hp = 4;
    fb[0] = 8'h01; fb[1] = 8'hAA; fb[2] = 8'hBB; fn = 3;
    model_frame();
    bus.spi_io_ss = 1'b0;
    wait_clk(hp);
    xfer(fb[0], 8, 1'b0, r);
    xfer(fb[1], 3, 1'b0, r);
    wait_clk(300);
    xfer(fb[1] << 3, 5, 1'b0, r);
    xfer(fb[2], 8, 1'b0, r);
    wait_clk(hp);
    bus.spi_io_ss = 1'b1;
    wait_clk(8);
    check("stall dout_hold", 32'(bus.mcu_dout), 32'(fb[2]));
    compare_events("stall");
`endif

    // Randomized frames.
    for (int k = 0; k < 12; k++) begin
      hp = int'($urandom_range(4, 7));
      fn = int'($urandom_range(1, 5));
      fb[0] = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
      for (int i = 1; i < fn; i++) fb[i] = 8'($urandom);
      set_din(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_frame("random", $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
